// File: rtl/core_pkg.sv
// Shared core definitions: ALU op encodings, forward/SrcA select codes and
// the values an ID/EX bubble carries.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_op_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  // A bubble is an all-zero slot: ADD op, rd=x0, no side effects, not valid.
  localparam alu_op_e    BUBBLE_ALU_OP     = ALU_ADD;
  localparam logic [1:0] BUBBLE_RESULT_SRC = 2'b00;
  localparam logic [1:0] BUBBLE_SRCA_SEL   = SRCA_RS1;
  localparam logic       BUBBLE_CTRL       = 1'b0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: D-side fields in, hazard controls and forwarding
// sources in, registered E fields and resolved ALU operands out.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            StallE, FlushE, ValidD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [RA_W-1:0] Rs1D, Rs2D, RdD;
  logic [3:0]      ALUControlD;
  logic [1:0]      SrcASelD;
  logic            ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]      ResultSrcD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ALUResultM, ResultW;

  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE;
  logic [3:0]      ALUControlE;
  logic [RA_W-1:0] Rs1E, Rs2E, RdE;
  logic [XLEN-1:0] PCE, PCPlus4E, ImmExtE;
  logic            RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
  logic [1:0]      ResultSrcE;

  modport master (
    output StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, ALUControlD, SrcASelD, ALUSrcD, RegWriteD,
           MemWriteD, BranchD, JumpD, ResultSrcD, ForwardAE, ForwardBE,
           ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, ALUControlE, Rs1E, Rs2E, RdE, PCE,
           PCPlus4E, ImmExtE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE,
           ResultSrcE
  );

  modport slave (
    input  StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, ALUControlD, SrcASelD, ALUSrcD, RegWriteD,
           MemWriteD, BranchD, JumpD, ResultSrcD, ForwardAE, ForwardBE,
           ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, ALUControlE, Rs1E, Rs2E, RdE, PCE,
           PCPlus4E, ImmExtE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE,
           ResultSrcE
  );
endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select: register value, writeback result or memory-stage
// ALU result, with reads of x0 always returning zero.
module fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [1:0]      i_sel,
  input  logic [RA_W-1:0] i_rs,
  input  logic [XLEN-1:0] i_reg,
  input  logic [XLEN-1:0] i_w,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_reg;
    if (i_rs == '0) begin
      o_data = '0;
    end else begin
      case (i_sel)
        FWD_W:   o_data = i_w;
        FWD_M:   o_data = i_m;
        default: o_data = i_reg;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, plus same-cycle forwarding and
// ALU operand selection for the execute stage.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic [XLEN-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
  logic [RA_W-1:0] r_rs1, r_rs2, r_rd;
  alu_op_e         r_alu_ctrl;
  logic [1:0]      r_srca_sel, r_result_src;
  logic            r_alu_src, r_reg_write, r_mem_write, r_branch, r_jump, r_valid;

  logic [XLEN-1:0] w_fa, w_fb, w_srca;

  // Flush beats stall so a squashed instruction can never linger in E.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_pc4        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_ctrl   <= BUBBLE_ALU_OP;
      r_srca_sel   <= BUBBLE_SRCA_SEL;
      r_result_src <= BUBBLE_RESULT_SRC;
      r_alu_src    <= BUBBLE_CTRL;
      r_reg_write  <= BUBBLE_CTRL;
      r_mem_write  <= BUBBLE_CTRL;
      r_branch     <= BUBBLE_CTRL;
      r_jump       <= BUBBLE_CTRL;
      r_valid      <= BUBBLE_CTRL;
    end else if (!bus.StallE) begin
      r_rd1        <= bus.RD1D;
      r_rd2        <= bus.RD2D;
      r_imm        <= bus.ImmExtD;
      r_pc         <= bus.PCD;
      r_pc4        <= bus.PCPlus4D;
      r_rs1        <= bus.Rs1D;
      r_rs2        <= bus.Rs2D;
      r_rd         <= bus.RdD;
      r_alu_ctrl   <= alu_op_e'(bus.ALUControlD);
      r_srca_sel   <= bus.SrcASelD;
      r_result_src <= bus.ResultSrcD;
      r_alu_src    <= bus.ALUSrcD;
      r_reg_write  <= bus.RegWriteD;
      r_mem_write  <= bus.MemWriteD;
      r_branch     <= bus.BranchD;
      r_jump       <= bus.JumpD;
      r_valid      <= bus.ValidD;
    end
  end

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
    .i_sel  (bus.ForwardAE),
    .i_rs   (r_rs1),
    .i_reg  (r_rd1),
    .i_w    (bus.ResultW),
    .i_m    (bus.ALUResultM),
    .o_data (w_fa)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
    .i_sel  (bus.ForwardBE),
    .i_rs   (r_rs2),
    .i_reg  (r_rd2),
    .i_w    (bus.ResultW),
    .i_m    (bus.ALUResultM),
    .o_data (w_fb)
  );

  always_comb begin
    w_srca = w_fa;
    case (r_srca_sel)
      SRCA_PC:   w_srca = r_pc;
      SRCA_ZERO: w_srca = '0;
      default:   w_srca = w_fa;
    endcase
  end

  assign bus.SrcAE       = w_srca;
  assign bus.SrcBE       = r_alu_src ? r_imm : w_fb;
  assign bus.WriteDataE  = w_fb;
  assign bus.ALUControlE = r_alu_ctrl;
  assign bus.Rs1E        = r_rs1;
  assign bus.Rs2E        = r_rs2;
  assign bus.RdE         = r_rd;
  assign bus.PCE         = r_pc;
  assign bus.PCPlus4E    = r_pc4;
  assign bus.ImmExtE     = r_imm;
  assign bus.RegWriteE   = r_reg_write;
  assign bus.MemWriteE   = r_mem_write;
  assign bus.BranchE     = r_branch;
  assign bus.JumpE       = r_jump;
  assign bus.ValidE      = r_valid;
  assign bus.ResultSrcE  = r_result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the E slot.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluc;
    logic [1:0]  srca_sel;
    logic        alusrc, regw, memw, br, jmp;
    logic [1:0]  rsrc;
    logic        valid;
  } d_t;

  localparam int W = 69;

  logic clk, rst_n;
  int   checks, failures;
  d_t   cur_d, m_e;
  logic [W-1:0] exp_q[$];

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  function automatic d_t rand_d();
    d_t d;
    d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom;
    d.pc = $urandom; d.pc4 = $urandom;
    d.rs1 = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
    d.rs2 = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
    d.rd = 5'($urandom); d.aluc = 4'($urandom); d.srca_sel = 2'($urandom);
    d.alusrc = 1'($urandom); d.valid = ($urandom_range(0, 4) != 0);
    d.regw = d.valid & 1'($urandom); d.memw = d.valid & 1'($urandom);
    d.br = d.valid & 1'($urandom); d.jmp = d.valid & 1'($urandom);
    d.rsrc = d.valid ? 2'($urandom) : 2'b00;
    return d;
  endfunction

  task automatic drive_d(input d_t d);
    cur_d = d;
    bus.RD1D = d.rd1; bus.RD2D = d.rd2; bus.ImmExtD = d.imm;
    bus.PCD = d.pc; bus.PCPlus4D = d.pc4;
    bus.Rs1D = d.rs1; bus.Rs2D = d.rs2; bus.RdD = d.rd;
    bus.ALUControlD = d.aluc; bus.SrcASelD = d.srca_sel; bus.ALUSrcD = d.alusrc;
    bus.RegWriteD = d.regw; bus.MemWriteD = d.memw; bus.BranchD = d.br;
    bus.JumpD = d.jmp; bus.ResultSrcD = d.rsrc; bus.ValidD = d.valid;
  endtask

  task automatic drive_fwd(input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] m, input logic [31:0] w);
    bus.ForwardAE = fa; bus.ForwardBE = fb; bus.ALUResultM = m; bus.ResultW = w;
  endtask

  // One clock: the model slot follows the reset > flush > stall > capture rules.
  task automatic step();
    @(posedge clk);
    if (!rst_n || bus.FlushE) m_e = '0;
    else if (!bus.StallE) m_e = cur_d;
    #1;
  endtask

  // reference model of the execute-side operands
  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [4:0] rs,
                                          input logic [31:0] regv);
    if (rs == 0) return 32'd0;
    if (sel == 2'b01) return bus.ResultW;
    if (sel == 2'b10) return bus.ALUResultM;
    return regv;
  endfunction

  function automatic logic [31:0] ref_srca(input d_t e);
    if (e.srca_sel == 2'b01) return e.pc;
    if (e.srca_sel == 2'b10) return 32'd0;
    return ref_fwd(bus.ForwardAE, e.rs1, e.rd1);
  endfunction

  function automatic logic [31:0] ref_srcb(input d_t e);
    return e.alusrc ? e.imm : ref_fwd(bus.ForwardBE, e.rs2, e.rd2);
  endfunction

  function automatic logic [31:0] ref_wdata(input d_t e);
    return ref_fwd(bus.ForwardBE, e.rs2, e.rd2);
  endfunction

  function automatic logic [146:0] e_regs_dut();
    return {bus.PCE, bus.PCPlus4E, bus.ImmExtE, bus.Rs1E, bus.Rs2E, bus.RdE,
            bus.ALUControlE, bus.RegWriteE, bus.MemWriteE, bus.BranchE,
            bus.JumpE, bus.ResultSrcE, bus.ValidE};
  endfunction

  function automatic logic [146:0] e_regs_ref(input d_t e);
    return {e.pc, e.pc4, e.imm, e.rs1, e.rs2, e.rd, e.aluc, e.regw, e.memw,
            e.br, e.jmp, e.rsrc, e.valid};
  endfunction

  // scenarios
  task automatic test_reset();
    d_t d;
    d = rand_d(); d.valid = 1'b1; d.regw = 1'b1; d.rs1 = 5'd9; d.rd = 5'd4;
    rst_n = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0;
    drive_d(d);
    drive_fwd(2'b10, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    step(); step();
    checks++;
    if (e_regs_dut() !== 147'd0) begin
      failures++; $display("FAIL reset_regs: got %h want 0", e_regs_dut());
    end
    checks++;
    if (bus.SrcAE !== 32'd0) begin
      failures++; $display("FAIL reset_srca: got %h want 0", bus.SrcAE);
    end
    checks++;
    if (bus.SrcBE !== 32'd0 || bus.WriteDataE !== 32'd0) begin
      failures++; $display("FAIL reset_srcb: got %h/%h want 0/0", bus.SrcBE, bus.WriteDataE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_plain_capture();
    d_t d;
    d = '0; d.rd1 = 32'd5; d.rd2 = 32'd7; d.aluc = 4'b0001;
    d.rs1 = 5'd1; d.rs2 = 5'd2; d.rd = 5'd3; d.valid = 1'b1; d.regw = 1'b1;
    drive_d(d); drive_fwd(2'b00, 2'b00, 32'hAAAA_0000, 32'hBBBB_0000);
    step();
    checks++;
    if (bus.SrcAE !== 32'd5 || bus.SrcBE !== 32'd7) begin
      failures++; $display("FAIL plain_src: got %h/%h want 5/7", bus.SrcAE, bus.SrcBE);
    end
    checks++;
    if (bus.ALUControlE !== 4'b0001 || bus.WriteDataE !== 32'd7) begin
      failures++; $display("FAIL plain_ctl: got %b/%h want 0001/7", bus.ALUControlE, bus.WriteDataE);
    end
    checks++;
    if (bus.RdE !== 5'd3 || bus.ValidE !== 1'b1 || bus.RegWriteE !== 1'b1) begin
      failures++; $display("FAIL plain_rd: got rd=%0d v=%b rw=%b want 3/1/1", bus.RdE, bus.ValidE, bus.RegWriteE);
    end
  endtask

  task automatic test_forwarding();
    d_t d;
    d = '0; d.rd1 = 32'h55; d.rs1 = 5'd3; d.rs2 = 5'd0; d.rd2 = 32'h66; d.valid = 1'b1;
    drive_d(d); drive_fwd(2'b00, 2'b00, 32'h0, 32'h0);
    step();
    drive_fwd(2'b10, 2'b10, 32'h100, 32'h0); #1;
    checks++;
    if (bus.SrcAE !== 32'h100) begin
      failures++; $display("FAIL fwd_m: got %h want 100", bus.SrcAE);
    end
    checks++;
    if (bus.WriteDataE !== 32'h0) begin
      failures++; $display("FAIL fwd_x0_rs2: got %h want 0", bus.WriteDataE);
    end
    drive_fwd(2'b01, 2'b00, 32'h100, 32'h200); #1;
    checks++;
    if (bus.SrcAE !== 32'h200) begin
      failures++; $display("FAIL fwd_w: got %h want 200", bus.SrcAE);
    end
    d.rs1 = 5'd0;
    drive_d(d); drive_fwd(2'b10, 2'b00, 32'h100, 32'h200);
    step();
    checks++;
    if (bus.SrcAE !== 32'h0) begin
      failures++; $display("FAIL fwd_x0_rs1: got %h want 0", bus.SrcAE);
    end
  endtask

  task automatic test_sources();
    d_t d;
    d = '0; d.alusrc = 1'b1; d.imm = 32'hFFFF_F800; d.rs2 = 5'd4; d.rd2 = 32'h33;
    d.rs1 = 5'd6; d.rd1 = 32'h77; d.valid = 1'b1;
    drive_d(d); drive_fwd(2'b00, 2'b10, 32'd9, 32'h0);
    step();
    checks++;
    if (bus.SrcBE !== 32'hFFFF_F800 || bus.WriteDataE !== 32'd9) begin
      failures++; $display("FAIL imm_src: got %h/%h want FFFFF800/9", bus.SrcBE, bus.WriteDataE);
    end
    d.srca_sel = 2'b01; d.pc = 32'h40;
    drive_d(d); step();
    checks++;
    if (bus.SrcAE !== 32'h40) begin
      failures++; $display("FAIL pc_src: got %h want 40", bus.SrcAE);
    end
    d.srca_sel = 2'b10;
    drive_d(d); step();
    checks++;
    if (bus.SrcAE !== 32'h0) begin
      failures++; $display("FAIL lui_src: got %h want 0", bus.SrcAE);
    end
    d.srca_sel = 2'b11;
    drive_d(d); step();
    checks++;
    if (bus.SrcAE !== 32'h77) begin
      failures++; $display("FAIL rs1_sel11: got %h want 77", bus.SrcAE);
    end
  endtask

  task automatic test_stall_flush();
    d_t a;
    a = rand_d(); a.valid = 1'b1; a.regw = 1'b1; a.rd = 5'd5;
    a.srca_sel = 2'b00; a.alusrc = 1'b0;
    drive_d(a); drive_fwd(2'b00, 2'b00, 32'h0, 32'h0);
    step();
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_d(rand_d());
      step();
      checks++;
      if (bus.PCE !== a.pc || bus.RdE !== a.rd || bus.ImmExtE !== a.imm || bus.ValidE !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d]: got pc=%h rd=%0d want pc=%h rd=%0d", i, bus.PCE, bus.RdE, a.pc, a.rd);
      end
      checks++;
      if (bus.SrcAE !== (a.rs1 == 0 ? 32'd0 : a.rd1)) begin
        failures++; $display("FAIL stall_srca[%0d]: got %h want %h", i, bus.SrcAE, (a.rs1 == 0 ? 32'd0 : a.rd1));
      end
    end
    bus.FlushE = 1'b1;
    step();
    checks++;
    if (bus.RegWriteE !== 1'b0 || bus.RdE !== 5'd0 || bus.ValidE !== 1'b0) begin
      failures++; $display("FAIL flush_over_stall: got rw=%b rd=%0d v=%b want 0/0/0", bus.RegWriteE, bus.RdE, bus.ValidE);
    end
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
  endtask

  task automatic test_back_to_back();
    d_t d;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    for (int i = 0; i < 20; i++) begin
      d = rand_d();
      drive_d(d);
      exp_q.push_back({d.pc, d.imm, d.rd});
      step();
      exp = exp_q.pop_front();
      got = {bus.PCE, bus.ImmExtE, bus.RdE};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL back_to_back[%0d]: got %h want %h", i, got, exp);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_queue: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_d(rand_d());
      rst_n = ($urandom_range(0, 32) != 0);
      bus.FlushE = ($urandom_range(0, 9) == 0);
      bus.StallE = ($urandom_range(0, 4) == 0);
      drive_fwd(2'($urandom), 2'($urandom), $urandom, $urandom);
      step();
      checks++;
      if (e_regs_dut() !== e_regs_ref(m_e)) begin
        failures++; $display("FAIL rand_regs[%0d]: got %h want %h", i, e_regs_dut(), e_regs_ref(m_e));
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (bus.SrcAE !== ref_srca(m_e) || bus.SrcBE !== ref_srcb(m_e) ||
            bus.WriteDataE !== ref_wdata(m_e)) begin
          failures++;
          $display("FAIL rand_ops[%0d.%0d]: got %h/%h/%h want %h/%h/%h", i, k,
                   bus.SrcAE, bus.SrcBE, bus.WriteDataE,
                   ref_srca(m_e), ref_srcb(m_e), ref_wdata(m_e));
        end
        drive_fwd(2'($urandom), 2'($urandom), $urandom, $urandom);
        #1;
      end
    end
    rst_n = 1'b1; bus.StallE = 1'b0; bus.FlushE = 1'b0;
  endtask

  // sequence and final report
  initial begin
    checks = 0; failures = 0;
    m_e = '0;
    test_reset();
    test_plain_capture();
    test_forwarding();
    test_sources();
    test_stall_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
